wts_wave_scheduler: RTL

WTS_WAVE_SCHEDULER -- requirements
Module: wts_wave_scheduler

---
 rtl/wts_pkg.sv | 10 +
 rtl/wts_cpu_port.sv | 83 ++++++++
 rtl/wts_wave_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/wts_pkg.sv
// Shared widths and FSM state type for the wave-RAM scheduler.
// Related build option: WTS_CPU_READBACK_EN (CPU read data returned from RAM).
package wts_pkg;
    localparam int unsigned WTS_RAM_AW  = 10;
    localparam int unsigned WTS_DATA_W  = 8;
    localparam int unsigned WTS_WADDR_W = 7;
    localparam int unsigned WTS_MAX_CH  = 8;

    typedef enum logic [1:0] {IDLE, RD, CPU, FIN} wts_state_e;
endpackage

// File: rtl/wts_cpu_port.sv
// One-entry CPU request holding register and ack/readback logic.
// WTS_CPU_READBACK_EN: reads access RAM and return data; otherwise reads are acked with zero data.
module wts_cpu_port
    import wts_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [WTS_RAM_AW-1:0] addr_i,
    input  logic [WTS_DATA_W-1:0] wdata_i,
    input  logic                  cpu_slot_i,
    input  logic                  fin_slot_i,
    input  logic [WTS_DATA_W-1:0] ram_rdata_i,
    output logic                  ack_o,
    output logic [WTS_DATA_W-1:0] rdata_o,
    output logic [WTS_RAM_AW-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [WTS_DATA_W-1:0] ram_wdata_o
);
`ifdef WTS_CPU_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic                  pend_q, pend_d;
    logic                  we_q, we_d;
    logic                  svc_q, svc_d;
    logic                  ack_q, ack_d;
    logic [WTS_RAM_AW-1:0] addr_q, addr_d;
    logic [WTS_DATA_W-1:0] wdata_q, wdata_d;
    logic [WTS_DATA_W-1:0] rdata_q, rdata_d;
    logic                  drive;

    // svc_q marks that the pending entry owned the CPU slot, so a request
    // latched during the CPU slot itself is not acked until the next frame.
    always_comb begin
        pend_d  = pend_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        svc_d   = cpu_slot_i & pend_q;
        ack_d   = fin_slot_i & svc_q;
        if (fin_slot_i && svc_q) begin
            pend_d = 1'b0;
            if (READBACK && !we_q) rdata_d = ram_rdata_i;
        end else if (req_i && !pend_q && !ack_q) begin
            pend_d  = 1'b1;
            we_d    = we_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            svc_q   <= 1'b0;
            ack_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            we_q    <= we_d;
            svc_q   <= svc_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign drive       = cpu_slot_i & pend_q & (we_q | READBACK);
    assign ram_addr_o  = drive ? addr_q : '0;
    assign ram_we_o    = drive & we_q;
    assign ram_wdata_o = drive ? wdata_q : '0;
    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
endmodule

// File: rtl/wts_wave_scheduler.sv
// Time-multiplexes one single-port wave RAM between NCH tone channels and a CPU port.
// Build option WTS_CPU_READBACK_EN (see wts_cpu_port) enables CPU read data.
module wts_wave_scheduler
    import wts_pkg::*;
#(
    parameter int unsigned NCH = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       active,
    input  logic [WTS_WADDR_W*NCH-1:0] wave_address,
    input  logic [NCH-1:0]             ch_enable,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [WTS_RAM_AW-1:0]      cpu_addr,
    input  logic [WTS_DATA_W-1:0]      cpu_wdata,
    output logic                       cpu_ack,
    output logic [WTS_DATA_W-1:0]      cpu_rdata,
    output logic [WTS_RAM_AW-1:0]      ram_addr,
    output logic                       ram_we,
    output logic [WTS_DATA_W-1:0]      ram_wdata,
    input  logic [WTS_DATA_W-1:0]      ram_rdata,
    output logic [WTS_DATA_W*NCH-1:0]  sample,
    output logic                       samples_valid,
    output logic                       overrun,
    input  logic                       overrun_clr
);
    localparam logic [2:0] LAST = 3'(NCH - 1);

    wts_state_e            state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic                  cap_q, cap_en_q;
    logic [2:0]            cap_idx_q;
    logic                  ovr_q, ovr_d;
    logic [WTS_DATA_W-1:0] samp_q [NCH];
    logic [WTS_DATA_W-1:0] samp_d [NCH];
    logic [WTS_WADDR_W-1:0] wa [WTS_MAX_CH];
    logic [WTS_MAX_CH-1:0]  en_pad;
    logic [WTS_RAM_AW-1:0]  cp_addr;
    logic                   cp_we;
    logic [WTS_DATA_W-1:0]  cp_wdata;

    // Pad channel views to 8 entries so the 3-bit idx always indexes in range.
    for (genvar g = 0; g < WTS_MAX_CH; g++) begin : g_ch
        if (g < NCH) begin : g_used
            assign wa[g]     = wave_address[WTS_WADDR_W*g +: WTS_WADDR_W];
            assign en_pad[g] = ch_enable[g];
        end else begin : g_pad
            assign wa[g]     = '0;
            assign en_pad[g] = 1'b0;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign sample[WTS_DATA_W*g +: WTS_DATA_W] = samp_q[g];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (active) begin
                state_d = RD;
                idx_d   = '0;
            end
            RD: if (idx_q == LAST) begin
                state_d = CPU;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
            CPU:     state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (state_q == RD) begin
            ram_addr = {idx_q, wa[idx_q]};
        end else if (state_q == CPU) begin
            ram_addr  = cp_addr;
            ram_we    = cp_we;
            ram_wdata = cp_wdata;
        end
    end

    // RAM data for slot idx arrives one cycle after its address slot.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            samp_d[i] = samp_q[i];
            if (cap_q && cap_idx_q == 3'(i)) samp_d[i] = cap_en_q ? ram_rdata : '0;
        end
    end

    assign ovr_d = (ovr_q & ~overrun_clr) | (active & (state_q != IDLE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cap_q     <= 1'b0;
            cap_idx_q <= '0;
            cap_en_q  <= 1'b0;
            ovr_q     <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) samp_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cap_q     <= (state_q == RD);
            cap_idx_q <= idx_q;
            cap_en_q  <= en_pad[idx_q];
            ovr_q     <= ovr_d;
            samp_q    <= samp_d;
        end
    end

    wts_cpu_port u_cpu_port (
        .clk_i       (clk),
        .rst_i       (reset),
        .req_i       (cpu_req),
        .we_i        (cpu_we),
        .addr_i      (cpu_addr),
        .wdata_i     (cpu_wdata),
        .cpu_slot_i  (state_q == CPU),
        .fin_slot_i  (state_q == FIN),
        .ram_rdata_i (ram_rdata),
        .ack_o       (cpu_ack),
        .rdata_o     (cpu_rdata),
        .ram_addr_o  (cp_addr),
        .ram_we_o    (cp_we),
        .ram_wdata_o (cp_wdata)
    );

    assign samples_valid = (state_q == FIN);
    assign overrun       = ovr_q;
endmodule
